// File: rtl/input_key_trigger_pkg.sv
// -----------------------------------------------------------------------------
// input_key_trigger_pkg
// Shared definitions for the push-button inference trigger:
//   - FSM state encodings (2 bits, kept as plain constants so the same codes
//     can be matched by older tooling and by the LED indicator block)
//   - helpers that derive the debounce length and counter widths from the
//     FREQUENCY / DEBOUNCE_MS convention used across the peripherals
// -----------------------------------------------------------------------------
package input_key_trigger_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_START = 2'd1;
    localparam logic [STATE_W-1:0] ST_BUSY  = 2'd2;

    // Clock cycles a key level must stay stable before it is accepted.
    function automatic int deb_cycles(input int frequency, input int debounce_ms);
        return (frequency / 1000) * debounce_ms;
    endfunction

    // Bits needed for a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/input_key_trigger_if.sv
// -----------------------------------------------------------------------------
// input_key_trigger_if
// Handshake between the key trigger and the inference core.
//   start        trigger -> core  one-cycle launch pulse
//   busy         trigger -> core  high from start until done or timeout
//   timeout_err  trigger -> core  sticky timeout flag
//   run_cnt[7:0] trigger -> core  accepted presses, wraps at 256
//   done         core -> trigger  one-cycle result-valid pulse
// master = trigger side, slave = inference core side.
// -----------------------------------------------------------------------------
interface input_key_trigger_if;

    logic       start;
    logic       busy;
    logic       timeout_err;
    logic [7:0] run_cnt;
    logic       done;

    modport master (
        output start,
        output busy,
        output timeout_err,
        output run_cnt,
        input  done
    );

    modport slave (
        input  start,
        input  busy,
        input  timeout_err,
        input  run_cnt,
        output done
    );

endinterface

// File: rtl/input_key_trigger_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes and debounces the active-low board key and reports presses.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_n        raw asynchronous key, 0 = pressed
//   key_db       debounced key level, 1 = released
//   press_pulse  one-cycle pulse when key_db falls 1 -> 0
// A level is accepted once the synchronized key has differed from key_db for
// DEB_CYCLES consecutive cycles; any matching cycle restarts the count.
// -----------------------------------------------------------------------------
module key_debounce
    import input_key_trigger_pkg::*;
#(
    parameter int DEB_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_db,
    output logic press_pulse
);

    localparam int            CW      = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [1:0]    sync_vld;
    logic          armed;
    logic [CW-1:0] cnt;

    // NOTE: the synchronizer and key_db reset to 1 (released) rather than 0,
    // otherwise every reset would look like a key press to the logic below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            sync_vld    <= 2'b00;
            armed       <= 1'b0;
            cnt         <= '0;
            key_db      <= 1'b1;
            press_pulse <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all flops see the values
            // from before this edge, independent of statement order.
            sync1       <= key_n;
            sync2       <= sync1;
            sync_vld    <= {sync_vld[0], 1'b1};
            press_pulse <= 1'b0;

            // sync2 only reflects the real key two edges after reset. A key
            // held through reset must be seen released before a press counts.
            if (sync_vld[1] && sync2 && key_db) begin
                armed <= 1'b1;
            end

            if (sync2 == key_db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                key_db      <= sync2;
                cnt         <= '0;
                press_pulse <= armed && !sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_key_trigger.sv
// -----------------------------------------------------------------------------
// input_key_trigger
// Launches one inference per debounced key press and supervises completion.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   key_n  raw board key, 0 = pressed
//   core   master side of input_key_trigger_if (start, busy, timeout_err,
//          run_cnt out; done in)
// FSM: IDLE -> START (one cycle, start pulse) -> BUSY until done or timeout.
// Presses arriving outside IDLE are dropped. All outputs are registered and
// computed from the next state so they line up with the state they describe.
// -----------------------------------------------------------------------------
module input_key_trigger
    import input_key_trigger_pkg::*;
#(
    parameter int FREQUENCY      = 50000000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int TIMEOUT_CYCLES = FREQUENCY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_n,
    input_key_trigger_if.master  core
);

    localparam int            DEB_CYCLES = deb_cycles(FREQUENCY, DEBOUNCE_MS);
    localparam int            TW         = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT_CYCLES - 1);

    logic               key_db;
    logic               press_pulse;
    logic               press_evt;
    logic               time_up;
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nx;
    logic [TW-1:0]      tcnt;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .key_db      (key_db),
        .press_pulse (press_pulse)
    );

    // The pulse is only honoured while the debounced level is actually low.
    assign press_evt = press_pulse && !key_db;

    // tcnt equals the number of cycles since the START cycle.
    assign time_up = (tcnt == T_LAST);

    // NOTE: state_nx gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (press_evt) state_nx = ST_START;
            ST_START: state_nx = core.done ? ST_IDLE : ST_BUSY;
            ST_BUSY:  if (core.done || time_up) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            tcnt             <= '0;
            core.start       <= 1'b0;
            core.busy        <= 1'b0;
            core.timeout_err <= 1'b0;
            core.run_cnt     <= 8'd0;
        end else begin
            state      <= state_nx;
            core.start <= (state_nx == ST_START);
            core.busy  <= (state_nx != ST_IDLE);

            if (state_nx == ST_START) begin
                tcnt             <= '0;
                core.run_cnt     <= core.run_cnt + 8'd1;
                core.timeout_err <= 1'b0;
            end else if (state != ST_IDLE) begin
                tcnt <= tcnt + 1'b1;
            end

            // done in the same cycle as the limit wins: no error.
            if (state == ST_BUSY && !core.done && time_up) begin
                core.timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_input_key_trigger.sv
// -----------------------------------------------------------------------------
// tb_input_key_trigger
// Scoreboard bench for input_key_trigger with FREQUENCY=1000, DEBOUNCE_MS=5
// (DEB_CYCLES=5) and TIMEOUT_CYCLES=50. The stimulus pushes the expected start
// cycle, run_cnt, busy length and final timeout_err of each launch; a monitor
// sampling on the falling clock edge pops and compares whenever start rises.
// -----------------------------------------------------------------------------
module tb_input_key_trigger;

    // First sampled low -> start: 2 sync + 5 debounce + 1 FSM.
    localparam int LAT = 8;

    typedef struct {
        int start_cyc;
        int run_cnt;
        int busy_len;   // -1: launch is expected to be cut short by reset
        int err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic key_n = 1'b1;
    int   cyc   = 0;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    exp_t sb[$];
    exp_t cur;
    bit   tracking   = 1'b0;
    int   blen       = 0;
    logic prev_start = 1'b0;

    input_key_trigger_if bus ();

    input_key_trigger #(
        .FREQUENCY      (1000),
        .DEBOUNCE_MS    (5),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n),
        .core  (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            if (tracking && cur.busy_len >= 0) begin
                check("busy_len_cut_by_reset", blen, cur.busy_len);
            end
            tracking   = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (bus.start === 1'b1) begin
                check("start_not_back_to_back", prev_start, 0);
                if (sb.size() == 0) begin
                    check("unexpected_start", bus.start, 0);
                end else begin
                    cur = sb.pop_front();
                    check("start_cycle", cyc, cur.start_cyc);
                    check("run_cnt_at_start", bus.run_cnt, cur.run_cnt);
                    check("err_clear_at_start", bus.timeout_err, 0);
                    tracking = 1'b1;
                    blen     = 0;
                end
            end
            if (tracking) begin
                if (bus.busy === 1'b1) begin
                    blen++;
                end else begin
                    tracking = 1'b0;
                    check("busy_len", blen, cur.busy_len);
                    check("timeout_err_after", bus.timeout_err, cur.err);
                end
            end
            prev_start = bus.start;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Returns at posedge+1 with cyc == target (or immediately if already past).
    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        wait_cyc(cyc + n);
    endtask

    // done is high during cycle 'at' (sampled on edge at+1).
    task automatic pulse_done(input int at);
        wait_cyc(at);
        bus.done = 1'b1;
        @(posedge clk);
        #1;
        bus.done = 1'b0;
    endtask

    task automatic press(output int s);
        @(posedge clk);
        #1;
        key_n = 1'b0;
        s = cyc + 1 + LAT;
    endtask

    task automatic expect_start(input int s, input int busy_len, input int err);
        exp_t e;
        exp_cnt    = (exp_cnt + 1) % 256;
        e.start_cyc = s;
        e.run_cnt   = exp_cnt;
        e.busy_len  = busy_len;
        e.err       = err;
        sb.push_back(e);
    endtask

    task automatic release_key();
        key_n = 1'b1;
        idle(12);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, bus.start, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_timeout_err"}, bus.timeout_err, 0);
        check({tag, "_run_cnt"}, bus.run_cnt, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s;
        bus.done = 1'b0;

        // Power-up reset.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(5);

        // Clean press, done 20 cycles after start: busy for 21 cycles.
        press(s);
        expect_start(s, 21, 0);
        pulse_done(s + 20);
        idle(5);
        release_key();

        // done while idle is ignored (any start here is unexpected).
        pulse_done(cyc + 2);
        idle(5);

        // Bounce: 3-cycle low/high segments for 30 cycles, then held low.
        for (int i = 0; i < 10; i++) begin
            key_n = logic'(i % 2);
            idle(3);
        end
        key_n = 1'b0;
        s = cyc + 1 + LAT;
        expect_start(s, 5, 0);
        pulse_done(s + 4);
        release_key();

        // Timeout: no done; busy drops 50 cycles after start, error sticks.
        press(s);
        expect_start(s, 50, 1);
        wait_cyc(s + 55);
        check("err_sticky", bus.timeout_err, 1);
        check("idle_after_timeout", bus.busy, 0);
        release_key();

        // Next press clears the error; done in the START cycle itself.
        press(s);
        expect_start(s, 1, 0);
        pulse_done(s);
        release_key();

        // Release/press during BUSY is dropped; done on the timeout limit.
        press(s);
        expect_start(s, 50, 0);
        wait_cyc(s + 3);
        key_n = 1'b1;
        wait_cyc(s + 15);
        key_n = 1'b0;
        pulse_done(s + 49);
        idle(25);
        check("no_queued_press_cnt", bus.run_cnt, exp_cnt);
        release_key();

        // Reset mid-run with the key held low.
        press(s);
        expect_start(s, -1, 0);
        wait_cyc(s + 10);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = 0;
        idle(30);
        check("held_key_no_start_busy", bus.busy, 0);
        release_key();
        press(s);
        expect_start(s, 3, 0);
        pulse_done(s + 2);
        release_key();

        // Wrap: 256 accepted presses from a fresh reset bring run_cnt to 0.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = 0;
        idle(4);
        for (int i = 0; i < 256; i++) begin
            press(s);
            expect_start(s, 1, 0);
            pulse_done(s);
            release_key();
        end
        check("run_cnt_wrap", bus.run_cnt, 0);

        idle(20);
        check("scoreboard_drained", sb.size(), 0);
        check("monitor_idle", tracking, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global bound on the run.
    initial begin
        #1000000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
